crc32_par: RTL and testbench
============================

CRC32_PAR -- requirements
Module: crc32_par

Interface
REQ-001 SHALL have parameter DATA_WD, default 32: input word width in bits; multiple of 8, range 8..64.
REQ-002 SHALL have parameter LANES, default 1: bytes folded into the CRC per cycle; SHALL divide DATA_WD/8.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1: begins a new message; reinitialises the CRC.
REQ-006 SHALL have port val_i, input, 1: dat_i is valid.
REQ-007 SHALL have port rdy_o, output, 1: the block accepts dat_i this cycle.
REQ-008 SHALL have port dat_i, input, DATA_WD: message word, MSB byte first.
REQ-009 SHALL have port lst_i, input, 1: the current word is the last of the message.
REQ-010 SHALL have port byt_i, input, max(1,clog2(DATA_WD/8)): valid byte count of the last word; 0 = full word; ignored unless lst_i is high.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse when the CRC is final.
REQ-012 SHALL have port val_o, output, 1: identical to done_o.
REQ-013 SHALL have port dat_o, output, 32: final PNG/IEEE CRC-32.

Function
REQ-014 SHALL compute reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, xorout 0xFFFFFFFF), bit-reflecting each input byte, over bytes in MSB-first order.
REQ-015 SHALL use states IDLE, RUN and DONE.
REQ-016 SHALL transition on start_i from any state to RUN, setting crc=0xFFFFFFFF and discarding any held word and beat count.
REQ-017 SHALL accept a word when val_i && rdy_o.
REQ-018 SHALL hold rdy_o low in IDLE, in DONE, and in any cycle where start_i is high.
REQ-019 SHALL drive rdy_o high in RUN when the hold register is empty or is in its final beat with a non-last word; a word every B=DATA_WD/(8*LANES) cycles SHALL be sustained with no bubble.
REQ-020 SHALL register each accepted word into a hold register; each following cycle (one beat) SHALL fold LANES bytes, most significant byte first.
REQ-021 SHALL limit a full word to B beats; a last word with k valid bytes SHALL take ceil(k/LANES) beats.
REQ-022 SHALL pass the CRC unchanged through lanes beyond k.
REQ-023 SHALL enter DONE the cycle after the final beat of the last word; in that cycle done_o=val_o=1 and dat_o=reflect(crc)^0xFFFFFFFF; the next cycle SHALL return to IDLE.
REQ-024 SHALL hold dat_o until the next DONE; start_i SHALL NOT clear it.
REQ-025 SHALL give a latency of 1+beats(last word) cycles from last-word acceptance to done_o.
REQ-026 SHALL not support zero-length messages; every message carries at least 1 byte.
REQ-027 SHALL ignore val_i in IDLE and DONE.
REQ-028 SHALL let start_i in the DONE cycle still emit done_o and then enter RUN (not IDLE).

Reset
REQ-029 SHALL, on rstn low, asynchronously set state=IDLE, crc=0xFFFFFFFF, hold register empty, beat count 0, rdy_o=0, done_o=0, val_o=0, dat_o=0.
REQ-030 SHALL discard any partial message on reset; no done_o follows.

Structure
REQ-031 SHALL take CRC32_POLY, CRC32_INIT, CRC32_XOROUT, CRC32_CHECK (0xCBF43926) and the state enum from shared package crc32_pkg.
REQ-032 SHALL use combinational sub-module crc32_lane (32-bit crc in + 8-bit reflected byte + enable -> 32-bit crc out), chained LANES times.

Verification
REQ-033 SHALL cover: DATA_WD=32, LANES=1; words 0x31323334, 0x35363738, 0x39000000 (lst, byt=1) -> done_o once, dat_o=0xCBF43926.
REQ-034 SHALL cover: DATA_WD=32, LANES=4; single word 0x49454E44 (lst, byt=0) -> dat_o=0xAE426082 two cycles after acceptance; rdy_o high every cycle on back-to-back words.
REQ-035 SHALL cover: DATA_WD=64, LANES=2; "123456789" as 0x3132333435363738, 0x3900000000000000 (byt=1) with random val_i gaps -> 0xCBF43926 and no rdy_o bubbles on continuous input.
REQ-036 SHALL cover: start_i mid-message, then "IEND" -> 0xAE426082; earlier bytes have no effect; no spurious done_o.
REQ-037 SHALL cover: rstn pulsed during a beat -> all outputs 0, then IDLE; rdy_o stays low until start_i.
REQ-038 SHALL cover: random lengths 1..64 and all byt_i values vs a software CRC-32 model; all results match.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, FSM state type and bit-reflection helpers for crc32_par.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_CHECK  = 32'hCBF4_3926;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } crc_state_e;

  function automatic logic [7:0] refl8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] refl32(input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = b[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_lane.sv
// One byte of MSB-first CRC-32 update; the byte arrives already bit-reflected.
module crc32_lane
  import crc32_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  input  logic        en_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {byte_i, 24'h0};
    for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
    crc_o = en_i ? c : crc_i;
  end

endmodule

// File: rtl/crc32_par.sv
// Streaming CRC-32 over MSB-first message words, LANES bytes folded per beat
// from a hold register that shifts left as its bytes are consumed.
module crc32_par
  import crc32_pkg::*;
#(
  parameter  int DATA_WD = 32,
  parameter  int LANES   = 1,
  localparam int NB      = DATA_WD / 8,
  localparam int BW      = (NB > 1) ? $clog2(NB) : 1,
  localparam int RW      = $clog2(NB + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               val_i,
  output logic               rdy_o,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic               lst_i,
  input  logic [BW-1:0]      byt_i,
  output logic               done_o,
  output logic               val_o,
  output logic [31:0]        dat_o
);

  crc_state_e         state_q, state_d;
  logic [31:0]        crc_q, crc_d;
  logic [DATA_WD-1:0] hold_q, hold_d;
  logic [RW-1:0]      rem_q, rem_d;     // bytes still to fold; 0 = hold empty
  logic               lst_q, lst_d;
  logic [31:0]        dat_q, dat_d;

  logic [LANES:0][31:0] chain;
  logic               beat, fin, rdy, acc;
  logic [RW-1:0]      nb_in;

  assign chain[0] = crc_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    crc32_lane u_lane (
      .crc_i  (chain[j]),
      .byte_i (refl8(hold_q[DATA_WD-1-8*j -: 8])),
      .en_i   (RW'(j) < rem_q),
      .crc_o  (chain[j+1])
    );
  end

  always_comb begin
    beat  = (state_q == RUN) && (rem_q != '0);
    fin   = beat && (rem_q <= RW'(LANES));
    // A non-last word may be replaced during its final beat, keeping one word per B cycles.
    rdy   = (state_q == RUN) && !start_i && (!beat || (fin && !lst_q));
    acc   = val_i && rdy;
    nb_in = (lst_i && (byt_i != '0)) ? RW'(byt_i) : RW'(NB);
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    lst_d   = lst_q;
    dat_d   = dat_q;
    if (start_i) begin
      state_d = RUN;
      crc_d   = CRC32_INIT;
      rem_d   = '0;
      lst_d   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (beat) begin
            crc_d  = chain[LANES];
            hold_d = hold_q << (8 * LANES);
            rem_d  = fin ? '0 : rem_q - RW'(LANES);
            if (fin && lst_q) begin
              state_d = DONE;
              dat_d   = refl32(chain[LANES]) ^ CRC32_XOROUT;
              lst_d   = 1'b0;
            end
          end
          if (acc) begin
            hold_d = dat_i;
            rem_d  = nb_in;
            lst_d  = lst_i;
          end
        end
        DONE: begin
          state_d = IDLE;
          crc_d   = CRC32_INIT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      crc_q   <= CRC32_INIT;
      hold_q  <= '0;
      rem_q   <= '0;
      lst_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      hold_q  <= hold_d;
      rem_q   <= rem_d;
      lst_q   <= lst_d;
      dat_q   <= dat_d;
    end
  end

  assign rdy_o  = rdy;
  assign done_o = (state_q == DONE);
  assign val_o  = done_o;
  assign dat_o  = dat_q;

endmodule

// File: tb/tb_crc32_par.sv
// Scoreboard bench for crc32_par in three configurations: (32,1), (32,4), (64,2).
module tb_crc32_par;
  import crc32_pkg::*;

  localparam int ND = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          d;
    logic [31:0] crc;
    int          acc;
    int          lat;
  } exp_t;

  int nbv [ND] = '{4, 4, 8};
  int lnv [ND] = '{1, 4, 2};

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [ND-1:0] start = '0, val = '0, lst = '0;
  logic [ND-1:0] rdy, done, vo;
  logic [63:0]   din [ND];
  logic [2:0]    byt [ND];
  logic [31:0]   dout [ND];

  exp_t sb[$];
  int   total = 0, bad = 0, ndone = 0, nmsg = 0, cyc = 0;

  crc32_par #(.DATA_WD(32), .LANES(1)) u_d0 (
    .clk(clk), .rstn(rstn), .start_i(start[0]), .val_i(val[0]), .rdy_o(rdy[0]),
    .dat_i(din[0][31:0]), .lst_i(lst[0]), .byt_i(byt[0][1:0]),
    .done_o(done[0]), .val_o(vo[0]), .dat_o(dout[0]));

  crc32_par #(.DATA_WD(32), .LANES(4)) u_d1 (
    .clk(clk), .rstn(rstn), .start_i(start[1]), .val_i(val[1]), .rdy_o(rdy[1]),
    .dat_i(din[1][31:0]), .lst_i(lst[1]), .byt_i(byt[1][1:0]),
    .done_o(done[1]), .val_o(vo[1]), .dat_o(dout[1]));

  crc32_par #(.DATA_WD(64), .LANES(2)) u_d2 (
    .clk(clk), .rstn(rstn), .start_i(start[2]), .val_i(val[2]), .rdy_o(rdy[2]),
    .dat_i(din[2]), .lst_i(lst[2]), .byt_i(byt[2]),
    .done_o(done[2]), .val_o(vo[2]), .dat_o(dout[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bytewise reflected reference (0xEDB88320 LSB-first form).
  function automatic logic [31:0] crc_ref(input bq_t m);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (m[i]) begin
      c = c ^ {24'h0, m[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      if (done[d] || vo[d]) begin
        chk("val_eq_done", 64'(vo[d]), 64'(done[d]));
        if (done[d]) begin
          ndone++;
          chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("dut_id", 64'(d), 64'(e.d));
            chk("crc", 64'(dout[d]), 64'(e.crc));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
        end
      end
    end
  end

  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic send_word(input int d, input logic [63:0] w, input bit l, input int b,
                           output int st, output int acc);
    val[d] = 1'b1; din[d] = w; lst[d] = l; byt[d] = 3'(b); st = 0;
    while (1) begin
      @(negedge clk);
      if (rdy[d]) break;
      st++;
      if (st > 500) begin
        chk("rdy_timeout", 64'(rdy[d]), 64'd1);
        break;
      end
    end
    acc = cyc;
    @(posedge clk); #1;
    val[d] = 1'b0; lst[d] = 1'b0; byt[d] = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic send_msg(input int d, input bq_t m, input int maxgap, input bit chkbub);
    int nb, nw, k, st, acc;
    logic [63:0] w;
    exp_t e;
    nb = nbv[d];
    pulse_start(d);
    nw = (m.size() + nb - 1) / nb;
    for (int i = 0; i < nw; i++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
      w = '0; k = 0;
      for (int b = 0; b < nb; b++)
        if (i * nb + b < m.size()) begin
          w = w | (64'(m[i*nb+b]) << (8 * (nb - 1 - b)));
          k++;
        end
      send_word(d, w, i == nw - 1, (k < nb) ? k : 0, st, acc);
      if (chkbub && i > 0) chk("bubble", 64'(st), 64'(nbv[d] / lnv[d] - 1));
      if (i == nw - 1) begin
        e.d = d; e.crc = crc_ref(m); e.acc = acc; e.lat = 1 + (k + lnv[d] - 1) / lnv[d];
        sb.push_back(e);
        nmsg++;
      end
    end
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t m;
    int st, acc, n, len;
    for (int d = 0; d < ND; d++) begin din[d] = '0; byt[d] = '0; end

    @(negedge clk);
    chk("rst_rdy", 64'(rdy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valo", 64'(vo), 64'd0);
    for (int d = 0; d < ND; d++) chk("rst_dout", 64'(dout[d]), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    val = '1;
    repeat (3) @(negedge clk);
    chk("idle_rdy", 64'(rdy), 64'd0);
    @(posedge clk); #1;
    val = '0;

    send_msg(0, s2q("123456789"), 0, 1);
    chk("check_w32l1", 64'(dout[0]), 64'(CRC32_CHECK));

    send_msg(1, s2q("IEND"), 0, 0);
    chk("iend_w32l4", 64'(dout[1]), 64'h0000_0000_AE42_6082);
    m.delete();
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    send_msg(1, m, 0, 1);

    send_msg(2, s2q("123456789"), 3, 0);
    chk("check_w64l2", 64'(dout[2]), 64'(CRC32_CHECK));
    m.delete();
    for (int i = 0; i < 32; i++) m.push_back(8'($urandom));
    send_msg(2, m, 0, 1);

    // Restart mid-message: held bytes and result register behaviour.
    pulse_start(0);
    chk("hold_thru_start", 64'(dout[0]), 64'(CRC32_CHECK));
    send_word(0, 64'h4142_4344, 1'b0, 0, st, acc);
    send_word(0, 64'h4546_4748, 1'b0, 0, st, acc);
    send_msg(0, s2q("IEND"), 0, 0);
    chk("iend_restart", 64'(dout[0]), 64'h0000_0000_AE42_6082);

    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 12; i++) begin
        len = (i < nbv[d]) ? i + 1 : int'($urandom_range(64, 1));
        m.delete();
        repeat (len) m.push_back(8'($urandom));
        send_msg(d, m, i % 3, 0);
      end

    // Reset in the middle of a multi-beat word.
    pulse_start(2);
    send_word(2, 64'h0102_0304_0506_0708, 1'b0, 0, st, acc);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("arst_rdy", 64'(rdy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_valo", 64'(vo), 64'd0);
    for (int d = 0; d < ND; d++) chk("arst_dout", 64'(dout[d]), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    val[2] = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[2] || done[2]) n++;
    end
    chk("post_rst_quiet", 64'(n), 64'd0);
    @(posedge clk); #1;
    val[2] = 1'b0;

    send_msg(2, s2q("IEND"), 1, 0);
    chk("iend_after_rst", 64'(dout[2]), 64'h0000_0000_AE42_6082);

    chk("done_count", 64'(ndone), 64'(nmsg));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
